// File: rtl/read_ctrl_pkg.sv
// Shared types and constants for the multi-channel read controller.
// Build option MULTI_CH_READ_RR_EN selects round-robin arbitration (default: fixed priority).
package read_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    VALID_OUTPUT  = 2'b01,
    UPDATE_OUTPUT = 2'b10
  } state_e;

  // Channel-index width, never narrower than one bit even for a single channel
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_VALID = 1'b0;
  localparam logic   RST_BUSY  = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requesting channel. With MULTI_CH_READ_RR_EN the search rotates from base,
// otherwise the lowest requesting index wins and base is ignored.
module rr_arbiter
  import read_ctrl_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   base,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

`ifdef MULTI_CH_READ_RR_EN
  int idx;

  // First requester found when walking upward from base, wrapping at NUM_CH
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = CH_W'(idx);
      end
    end
  end
`else
  logic unused_base;
  assign unused_base = ^base;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any && req[i]) begin
        any   = 1'b1;
        grant = CH_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/multi_ch_read_controller.sv
// Read-side controller for NUM_CH circular buffers sharing one read port.
// Build option MULTI_CH_READ_RR_EN enables round-robin arbitration across channels.
module multi_ch_read_controller
  import read_ctrl_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] r_en,
  input  logic [NUM_CH-1:0] empty,
  input  logic              out_ready,
  output logic              valid,
  output logic [CH_W-1:0]   ch_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [NUM_CH-1:0] r_cnt,
  output logic              busy
);

  state_e              state_q;
  logic [CH_W-1:0]     cur_ch_q;
  logic                valid_q;
  logic                busy_q;
  logic [NUM_CH-1:0]   r_cnt_q;
  logic [CH_W-1:0]     ch_id_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   ptr_q [NUM_CH];

  logic [NUM_CH-1:0]   req;
  logic [CH_W-1:0]     arb_base;
  logic [CH_W-1:0]     grant;
  logic                any_req;

  assign req = r_en & ~empty;

`ifdef MULTI_CH_READ_RR_EN
  logic [CH_W-1:0] arb_ptr_q;
  logic [CH_W-1:0] arb_ptr_d;

  assign arb_ptr_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);

  // Only a completed transfer moves the search start; aborts leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_ptr_q <= '0;
    end else if (state_q == UPDATE_OUTPUT) begin
      arb_ptr_q <= arb_ptr_d;
    end
  end

  assign arb_base = arb_ptr_q;
`else
  assign arb_base = '0;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .req   (req),
    .base  (arb_base),
    .grant (grant),
    .any   (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ptr_q[i] <= '0;
    end else if (state_q == UPDATE_OUTPUT) begin
      ptr_q[cur_ch_q] <= ptr_q[cur_ch_q] + ADDR_W'(1);
    end
  end

  // Outputs are loaded alongside the state so they are pure register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      cur_ch_q  <= '0;
      valid_q   <= RST_VALID;
      busy_q    <= RST_BUSY;
      r_cnt_q   <= '0;
      ch_id_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      valid_q <= 1'b0;
      r_cnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= VALID_OUTPUT;
            cur_ch_q  <= grant;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            ch_id_q   <= grant;
            rd_addr_q <= ptr_q[grant];
          end
        end
        VALID_OUTPUT: begin
          if (out_ready) begin
            state_q <= UPDATE_OUTPUT;
            r_cnt_q <= NUM_CH'(1) << cur_ch_q;
          end else if (!r_en[cur_ch_q] || empty[cur_ch_q]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            valid_q <= 1'b1;
          end
        end
        UPDATE_OUTPUT: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          rd_addr_q <= ptr_q[cur_ch_q] + ADDR_W'(1);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid   = valid_q;
  assign busy    = busy_q;
  assign r_cnt   = r_cnt_q;
  assign ch_id   = ch_id_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_multi_ch_read_controller.sv
// Randomized and directed bench for multi_ch_read_controller against a transaction-level model.
// Honours MULTI_CH_READ_RR_EN when choosing the expected arbitration order.
module tb_multi_ch_read_controller;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] empty;
  logic              out_ready;
  logic              valid;
  logic [1:0]        ch_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [NUM_CH-1:0] r_cnt;
  logic              busy;

  int compareCount;
  int mismatchCount;

  // Model: the channel currently offered to the consumer, the channel being popped,
  // the last channel granted, each channel's read position and the rotation start
  int mOffer;
  int mPop;
  int mLast;
  int mPtr [NUM_CH];
  int mRr;

  int seenCh [$];
  int seenAddr [$];

  multi_ch_read_controller #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_en      (r_en),
    .empty     (empty),
    .out_ready (out_ready),
    .valid     (valid),
    .ch_id     (ch_id),
    .rd_addr   (rd_addr),
    .r_cnt     (r_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOffer = -1;
    mPop   = -1;
    mLast  = 0;
    mRr    = 0;
    for (int i = 0; i < NUM_CH; i++) mPtr[i] = 0;
  endtask

  // One clock of behaviour, evaluated from the inputs present at the rising edge
  task automatic modelStep();
    int pick;
    if (!rst_n) begin
      modelReset();
    end else if (mPop >= 0) begin
      mPtr[mPop] = (mPtr[mPop] + 1) % DEPTH;
`ifdef MULTI_CH_READ_RR_EN
      mRr = (mPop + 1) % NUM_CH;
`endif
      mPop = -1;
    end else if (mOffer >= 0) begin
      if (out_ready) begin
        mPop   = mOffer;
        mOffer = -1;
      end else if (!r_en[mOffer] || empty[mOffer]) begin
        mOffer = -1;
      end
    end else begin
      pick = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
`ifdef MULTI_CH_READ_RR_EN
        c = (mRr + k) % NUM_CH;
`else
        c = k;
`endif
        if (pick < 0 && r_en[c] && !empty[c]) pick = c;
      end
      if (pick >= 0) begin
        mOffer = pick;
        mLast  = pick;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("valid", 32'(valid), 32'(mOffer >= 0));
    checkOutput("busy", 32'(busy), 32'(mOffer >= 0 || mPop >= 0));
    checkOutput("r_cnt", 32'(r_cnt), (mPop >= 0) ? (32'd1 << mPop) : 32'd0);
    checkOutput("ch_id", 32'(ch_id), 32'(mLast));
    checkOutput("rd_addr", 32'(rd_addr), 32'(mPtr[mLast]));
    if (valid) begin
      seenCh.push_back(int'(ch_id));
      seenAddr.push_back(int'(rd_addr));
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] ren, input logic [NUM_CH-1:0] emp, input logic rdy);
    r_en      = ren;
    empty     = emp;
    out_ready = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n     = 1'b0;
    r_en      = '0;
    empty     = '0;
    out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_rdaddr", 32'(rd_addr), 32'd0);

    // Single request on channel 1
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("first_valid", 32'(valid), 32'd1);
    checkOutput("first_ch", 32'(ch_id), 32'd1);
    checkOutput("first_addr", 32'(rd_addr), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("first_rcnt", 32'(r_cnt), 32'b0010);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("first_busy", 32'(busy), 32'd0);

    // Nine pops of channel 0 wrap its address after DEPTH reads
    seenAddr.delete();
    for (int i = 0; i < 27; i++) applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("wrap_count", 32'(seenAddr.size()), 32'd9);
    for (int i = 0; i < seenAddr.size() && i < 9; i++)
      checkOutput("wrap_addr", 32'(seenAddr[i]), 32'(i % DEPTH));

    // All channels requesting continuously from a fresh reset
    applyStimulus('0, '0, 1'b0);
    doReset();
    seenCh.delete();
    for (int i = 0; i < 15; i++) applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("arb_count", 32'(seenCh.size()), 32'd5);
    for (int i = 0; i < seenCh.size() && i < 5; i++) begin
`ifdef MULTI_CH_READ_RR_EN
      checkOutput("arb_order", 32'(seenCh[i]), 32'(i % NUM_CH));
`else
      checkOutput("arb_order", 32'(seenCh[i]), 32'd0);
`endif
    end

    // Stall, then abort by dropping the request without ready
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkOutput("stall_valid", 32'(valid), 32'd1);
    checkOutput("stall_ch", 32'(ch_id), 32'd2);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("abort_valid", 32'(valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("abort_rcnt", 32'(r_cnt), 32'd0);

    // Request drop together with ready still completes the pop
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("ready_wins", 32'(r_cnt), 32'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Requesting but empty channel is never granted
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 4'b0100, 1'b1);
    checkOutput("empty_valid", 32'(valid), 32'd0);
    checkOutput("empty_busy", 32'(busy), 32'd0);

    // Reset asserted while a pop strobe is out
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("pre_rst_rcnt", 32'(r_cnt), 32'b0010);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rcnt", 32'(r_cnt), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    applyStimulus('0, '0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      applyStimulus(4'(1 << c), 4'b0000, 1'b0);
      checkOutput("rst_ptr", 32'(rd_addr), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    applyStimulus('0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
